// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the round-robin AXI4-Stream packet arbiter.
package axis_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int MAX_NUM_SRC = 16;
  localparam int MAX_IDX_W   = 4;

  // Index of the set bit in a one-hot vector; zero for an all-zero vector.
  function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_NUM_SRC-1:0] onehot);
    logic [MAX_IDX_W-1:0] idx;
    idx = {MAX_IDX_W{1'b0}};
    for (int i = 0; i < MAX_NUM_SRC; i++) begin
      if (onehot[i]) begin
        idx = idx | MAX_IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/axis_rr_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate the requests so the slot after
// last_idx sits at bit 0, take the lowest set bit, rotate the result back.
module rr_picker
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic [NUM_SRC-1:0] gnt,
  output logic               found
);

  logic [IDX_W-1:0]     start_s;
  logic [2*NUM_SRC-1:0] req2_s;
  logic [2*NUM_SRC-1:0] back2_s;
  logic [NUM_SRC-1:0]   rot_s;
  logic [NUM_SRC-1:0]   pe_s;

  // Search start wraps from the top source back to source 0.
  always_comb begin
    start_s = {IDX_W{1'b0}};
    if (last_idx == IDX_W'(NUM_SRC - 1)) begin
      start_s = {IDX_W{1'b0}};
    end else begin
      start_s = last_idx + IDX_W'(1);
    end
  end

  // Rotate, priority-encode (lowest index wins), rotate back.
  always_comb begin
    req2_s = {req, req} >> start_s;
    rot_s  = req2_s[NUM_SRC-1:0];
    pe_s   = {NUM_SRC{1'b0}};
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (rot_s[i]) begin
        pe_s = NUM_SRC'(1) << i;
      end else begin
        pe_s = pe_s;
      end
    end
    back2_s = {{NUM_SRC{1'b0}}, pe_s} << start_s;
    gnt     = back2_s[NUM_SRC-1:0] | back2_s[2*NUM_SRC-1:NUM_SRC];
    found   = |req;
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin packet arbiter: shares one AXI4-Stream sink between NUM_SRC
// sources, granting whole packets or bursts of at most MAX_BURST beats.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 4,
  parameter int MAX_BURST  = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [NUM_SRC-1:0]            S_TVALID,
  output logic [NUM_SRC-1:0]            S_TREADY,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] S_TDATA,
  input  logic [NUM_SRC-1:0]            S_TLAST,
  output logic                          M_TVALID,
  input  logic                          M_TREADY,
  output logic [DATA_WIDTH-1:0]         M_TDATA,
  output logic                          M_TLAST,
  output logic [NUM_SRC-1:0]            GRANT,
  output logic                          BUSY
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t              state_r, state_n_s;
  logic [NUM_SRC-1:0]      grant_r, grant_n_s;
  logic [IDX_W-1:0]        grant_idx_r, grant_idx_n_s;
  logic [IDX_W-1:0]        last_grant_r, last_grant_n_s;
  logic [CNT_W-1:0]        beat_cnt_r, beat_cnt_n_s;
  logic                    m_tvalid_r;
  logic [DATA_WIDTH-1:0]   m_tdata_r;
  logic                    m_tlast_r;

  logic [NUM_SRC-1:0]      pick_s;
  logic                    found_s;
  logic [MAX_IDX_W-1:0]    pick_full_s;
  logic [IDX_W-1:0]        pick_idx_s;
  logic                    load_ok_s;
  logic [NUM_SRC-1:0]      ready_s;
  logic                    hs_s;
  logic [DATA_WIDTH-1:0]   sel_data_s;
  logic                    sel_last_s;
  logic                    exit_s;

  rr_picker #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req      (S_TVALID),
    .last_idx (last_grant_r),
    .gnt      (pick_s),
    .found    (found_s)
  );

  // Binary index of the picked source, kept alongside the one-hot grant.
  always_comb begin
    pick_full_s = onehot2idx(MAX_NUM_SRC'(pick_s));
    pick_idx_s  = pick_full_s[IDX_W-1:0];
  end

  // Only the granted source sees ready, and only when the output slot can take a beat.
  always_comb begin
    load_ok_s  = !m_tvalid_r || M_TREADY;
    sel_data_s = S_TDATA[int'(grant_idx_r)*DATA_WIDTH +: DATA_WIDTH];
    sel_last_s = S_TLAST[grant_idx_r];
    ready_s    = {NUM_SRC{1'b0}};
    if ((state_r == XFER) && load_ok_s) begin
      ready_s = grant_r;
    end else begin
      ready_s = {NUM_SRC{1'b0}};
    end
    hs_s   = |(S_TVALID & ready_s);
    exit_s = hs_s && (sel_last_s || (beat_cnt_r == CNT_W'(MAX_BURST - 1)));
  end

  // Next-state logic; a forced burst exit never alters tlast.
  always_comb begin
    state_n_s      = state_r;
    grant_n_s      = grant_r;
    grant_idx_n_s  = grant_idx_r;
    last_grant_n_s = last_grant_r;
    beat_cnt_n_s   = beat_cnt_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_n_s     = XFER;
          grant_n_s     = pick_s;
          grant_idx_n_s = pick_idx_s;
          beat_cnt_n_s  = {CNT_W{1'b0}};
        end else begin
          state_n_s = IDLE;
        end
      end
      XFER: begin
        if (exit_s) begin
          state_n_s      = IDLE;
          grant_n_s      = {NUM_SRC{1'b0}};
          last_grant_n_s = grant_idx_r;
          beat_cnt_n_s   = beat_cnt_r + CNT_W'(1);
        end else if (hs_s) begin
          beat_cnt_n_s = beat_cnt_r + CNT_W'(1);
        end else begin
          beat_cnt_n_s = beat_cnt_r;
        end
      end
      default: begin
        state_n_s = IDLE;
        grant_n_s = {NUM_SRC{1'b0}};
      end
    endcase
  end

  // Arbitration state registers; last_grant resets so source 0 wins first.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_r      <= IDLE;
      grant_r      <= {NUM_SRC{1'b0}};
      grant_idx_r  <= {IDX_W{1'b0}};
      last_grant_r <= IDX_W'(NUM_SRC - 1);
      beat_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_n_s;
      grant_r      <= grant_n_s;
      grant_idx_r  <= grant_idx_n_s;
      last_grant_r <= last_grant_n_s;
      beat_cnt_r   <= beat_cnt_n_s;
    end
  end

  // One-entry output register: load on source handshake, otherwise drain on ready.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      m_tvalid_r <= 1'b0;
      m_tdata_r  <= {DATA_WIDTH{1'b0}};
      m_tlast_r  <= 1'b0;
    end else if (hs_s) begin
      m_tvalid_r <= 1'b1;
      m_tdata_r  <= sel_data_s;
      m_tlast_r  <= sel_last_s;
    end else if (M_TREADY) begin
      m_tvalid_r <= 1'b0;
    end else begin
      m_tvalid_r <= m_tvalid_r;
    end
  end

  assign S_TREADY = ready_s;
  assign M_TVALID = m_tvalid_r;
  assign M_TDATA  = m_tdata_r;
  assign M_TLAST  = m_tlast_r;
  assign GRANT    = grant_r;
  assign BUSY     = (state_r == XFER);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: queue-driven sources, a packet-level
// round-robin model for expected order, and cycle checks on the handshake rules.
module tb_axis_rr_arbiter;

  localparam int DW = 32;
  localparam int NS = 4;
  localparam int MB = 4;

  logic                ACLK = 1'b0;
  logic                ARESETN;
  logic [NS-1:0]       S_TVALID, S_TREADY, S_TLAST, GRANT;
  logic [NS*DW-1:0]    S_TDATA;
  logic                M_TVALID, M_TREADY, M_TLAST, BUSY;
  logic [DW-1:0]       M_TDATA;

  always #5 ACLK = ~ACLK;

  axis_rr_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .MAX_BURST(MB)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_TVALID(S_TVALID), .S_TREADY(S_TREADY), .S_TDATA(S_TDATA), .S_TLAST(S_TLAST),
    .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA), .M_TLAST(M_TLAST),
    .GRANT(GRANT), .BUSY(BUSY)
  );

  int checks = 0;
  int failures = 0;

  logic [DW:0] srcq [NS][$];
  logic [DW:0] exp_out [$];
  int          exp_src [$];
  logic [DW:0] inj_q [$];
  int ready_mode, stall_src, stall_at, stall_len, stall_cnt, inj_cycle, inj_src;
  int popped [NS];

  logic [NS-1:0] tl_grant [$];
  logic [NS-1:0] tl_ready [$];
  logic          tl_mv [$];
  logic          tl_last [$];
  logic [DW-1:0] tl_data [$];

  task automatic drive_inputs();
    logic [DW:0] h;
    for (int i = 0; i < NS; i++) begin
      if (srcq[i].size() > 0 && !(stall_cnt > 0 && i == stall_src)) begin
        h = srcq[i][0];
        S_TVALID[i] = 1'b1;
        S_TDATA[i*DW +: DW] = h[DW-1:0];
        S_TLAST[i] = h[DW];
      end else begin
        S_TVALID[i] = 1'b0;
        S_TDATA[i*DW +: DW] = $urandom;
        S_TLAST[i] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  // Packet-level model: next non-empty source after the last one served,
  // take beats until tlast or MB beats, repeat.
  task automatic build_expected(input int last_in);
    logic [DW:0] q [NS][$];
    logic [DW:0] b;
    int last, s, n, c;
    for (int i = 0; i < NS; i++) q[i] = srcq[i];
    last = last_in;
    while (1) begin
      s = -1;
      for (int k = 1; k <= NS; k++) begin
        c = (last + k) % NS;
        if (s < 0 && q[c].size() > 0) s = c;
      end
      if (s < 0) break;
      n = 0;
      do begin
        b = q[s].pop_front();
        exp_out.push_back(b);
        exp_src.push_back(s);
        n++;
      end while (!b[DW] && n < MB && q[s].size() > 0);
      last = s;
    end
  endtask

  task automatic reset_dut();
    ARESETN = 1'b0;
    M_TREADY = 1'b1;
    ready_mode = 0;
    stall_src = -1; stall_at = 0; stall_len = 0; stall_cnt = 0;
    inj_cycle = -1; inj_src = 0;
    inj_q.delete(); exp_out.delete(); exp_src.delete();
    for (int i = 0; i < NS; i++) begin srcq[i].delete(); popped[i] = 0; end
    drive_inputs();
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(posedge ACLK);
    #1;
  endtask

  task automatic run(input int max_cyc, input bit need_done);
    int cyc, tail, hs, e_src, gap;
    bit done, held_v, prev_busy, had_busy;
    logic [DW:0] held, e;
    logic [NS-1:0] eg;
    cyc = 0; tail = 0; gap = 0; done = 1'b0;
    held_v = 1'b0; prev_busy = 1'b0; had_busy = 1'b0; held = '0;
    tl_grant.delete(); tl_ready.delete(); tl_mv.delete(); tl_last.delete(); tl_data.delete();
    drive_inputs();
    while (cyc < max_cyc) begin
      @(negedge ACLK);
      tl_grant.push_back(GRANT); tl_ready.push_back(S_TREADY);
      tl_mv.push_back(M_TVALID); tl_last.push_back(M_TLAST); tl_data.push_back(M_TDATA);
      checks++;
      if ($countones(S_TREADY) > 1 || (S_TREADY & ~GRANT) != '0) begin
        failures++; $display("FAIL ready_onehot cyc=%0d got tready=%b grant=%b", cyc, S_TREADY, GRANT);
      end
      checks++;
      if (BUSY ? !$onehot(GRANT) : (GRANT != '0)) begin
        failures++; $display("FAIL grant_busy cyc=%0d got grant=%b busy=%b", cyc, GRANT, BUSY);
      end
      if (held_v) begin
        checks++;
        if ({M_TLAST, M_TDATA} !== held) begin
          failures++; $display("FAIL hold_stable cyc=%0d got %h want %h", cyc, {M_TLAST, M_TDATA}, held);
        end
      end
      if (BUSY && !prev_busy && had_busy) begin
        checks++;
        if (gap != 1) begin
          failures++; $display("FAIL rearb_gap cyc=%0d got %0d idle cycles want 1", cyc, gap);
        end
      end
      if (!BUSY) gap++; else begin gap = 0; had_busy = 1'b1; end
      prev_busy = BUSY;
      if (stall_cnt > 0) begin
        eg = NS'(1) << stall_src;
        checks++;
        if (GRANT !== eg) begin
          failures++; $display("FAIL stall_grant cyc=%0d got %b want %b", cyc, GRANT, eg);
        end
      end
      hs = -1;
      for (int i = 0; i < NS; i++) if (S_TVALID[i] && S_TREADY[i]) hs = i;
      if (hs >= 0) begin
        checks++;
        if (exp_src.size() == 0) begin
          failures++; $display("FAIL grant_order cyc=%0d got src %0d want none", cyc, hs);
        end else begin
          e_src = exp_src.pop_front();
          if (e_src != hs) begin
            failures++; $display("FAIL grant_order cyc=%0d got src %0d want src %0d", cyc, hs, e_src);
          end
        end
      end
      if (M_TVALID && M_TREADY) begin
        checks++;
        if (exp_out.size() == 0) begin
          failures++; $display("FAIL extra_beat cyc=%0d got %h want none", cyc, {M_TLAST, M_TDATA});
        end else begin
          e = exp_out.pop_front();
          if ({M_TLAST, M_TDATA} !== e) begin
            failures++; $display("FAIL out_beat cyc=%0d got last,data=%h want %h", cyc, {M_TLAST, M_TDATA}, e);
          end
        end
      end
      held_v = M_TVALID && !M_TREADY;
      held = {M_TLAST, M_TDATA};
      @(posedge ACLK);
      #1;
      if (stall_cnt > 0) stall_cnt--;
      if (hs >= 0) begin
        void'(srcq[hs].pop_front());
        popped[hs]++;
        if (hs == stall_src && popped[hs] == stall_at) stall_cnt = stall_len;
      end
      cyc++;
      if (cyc == inj_cycle) begin
        for (int k = 0; k < inj_q.size(); k++) begin
          srcq[inj_src].push_back(inj_q[k]);
          exp_out.push_back(inj_q[k]);
          exp_src.push_back(inj_src);
        end
      end
      case (ready_mode)
        1: M_TREADY = ~M_TREADY;
        2: M_TREADY = ($urandom_range(0, 3) != 0);
        default: M_TREADY = 1'b1;
      endcase
      drive_inputs();
      done = (exp_out.size() == 0) && (cyc >= inj_cycle);
      for (int i = 0; i < NS; i++) if (srcq[i].size() > 0) done = 1'b0;
      if (done) tail++;
      if (tail >= 3) break;
    end
    if (need_done) begin
      checks++;
      if (!done) begin
        failures++; $display("FAIL run_timeout got %0d beats outstanding want 0", exp_out.size());
      end
    end
  endtask

  task automatic test_reset();
    S_TVALID = '1;
    ARESETN = 1'b0;
    #1;
    checks++;
    if ({M_TVALID, M_TLAST, M_TDATA, S_TREADY, GRANT, BUSY} !== '0) begin
      failures++;
      $display("FAIL reset_values got mv=%b ml=%b md=%h rdy=%b gnt=%b busy=%b want all 0",
               M_TVALID, M_TLAST, M_TDATA, S_TREADY, GRANT, BUSY);
    end
    reset_dut();
  endtask

  task automatic test_single();
    logic [DW-1:0] want [3];
    want[0] = 32'hA1; want[1] = 32'hA2; want[2] = 32'hA3;
    reset_dut();
    for (int k = 0; k < 3; k++) srcq[0].push_back({(k == 2), want[k]});
    build_expected(NS - 1);
    run(40, 1'b1);
    checks++;
    if (tl_mv.size() < 6) begin
      failures++; $display("FAIL single_timeline got %0d samples want >=6", tl_mv.size());
    end else begin
      if (tl_grant[0] !== 4'b0000 || tl_mv[0] !== 1'b0) begin
        failures++; $display("FAIL single_t0 got grant=%b mv=%b want 0000 0", tl_grant[0], tl_mv[0]);
      end
      checks++;
      if (tl_grant[1] !== 4'b0001 || tl_ready[1] !== 4'b0001 || tl_mv[1] !== 1'b0) begin
        failures++; $display("FAIL single_t1 got grant=%b rdy=%b mv=%b want 0001 0001 0", tl_grant[1], tl_ready[1], tl_mv[1]);
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (tl_mv[2+k] !== 1'b1 || tl_data[2+k] !== want[k] || tl_last[2+k] !== (k == 2)) begin
          failures++; $display("FAIL single_beat%0d got mv=%b data=%h last=%b want 1 %h %b",
                               k, tl_mv[2+k], tl_data[2+k], tl_last[2+k], want[k], (k == 2));
        end
      end
      checks++;
      if (tl_grant[3] !== 4'b0001 || tl_grant[4] !== 4'b0000 || tl_mv[5] !== 1'b0) begin
        failures++; $display("FAIL single_end got g3=%b g4=%b mv5=%b want 0001 0000 0", tl_grant[3], tl_grant[4], tl_mv[5]);
      end
    end
  endtask

  task automatic test_contention();
    reset_dut();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NS; s++)
        for (int b = 0; b < 2; b++)
          srcq[s].push_back({(b == 1), 32'(s * 256 + p * 16 + b)});
    build_expected(NS - 1);
    run(200, 1'b1);
  endtask

  task automatic test_burst_cap();
    reset_dut();
    for (int b = 0; b < 10; b++) srcq[2].push_back({(b == 9), 32'(32'h200 + b)});
    for (int b = 0; b < 3; b++) srcq[3].push_back({(b == 2), 32'(32'h300 + b)});
    build_expected(NS - 1);
    run(200, 1'b1);
  endtask

  task automatic test_toggle_ready();
    reset_dut();
    ready_mode = 1;
    for (int b = 0; b < 6; b++) srcq[0].push_back({(b == 5), 32'(32'h10 + b)});
    build_expected(NS - 1);
    run(200, 1'b1);
  endtask

  task automatic test_stall();
    reset_dut();
    for (int b = 0; b < 4; b++) srcq[1].push_back({(b == 3), 32'(32'h110 + b)});
    build_expected(NS - 1);
    for (int b = 0; b < 2; b++) inj_q.push_back({(b == 1), 32'(32'h0E0 + b)});
    inj_src = 0; inj_cycle = 3;
    stall_src = 1; stall_at = 2; stall_len = 5;
    run(200, 1'b1);
  endtask

  task automatic test_reset_mid_packet();
    reset_dut();
    for (int b = 0; b < 6; b++) srcq[1].push_back({(b == 5), 32'(32'h500 + b)});
    build_expected(NS - 1);
    run(4, 1'b0);
    #2;
    checks++;
    if (M_TVALID !== 1'b1 || GRANT !== 4'b0010) begin
      failures++; $display("FAIL pre_reset got mv=%b grant=%b want 1 0010", M_TVALID, GRANT);
    end
    ARESETN = 1'b0;
    #1;
    checks++;
    if (M_TVALID !== 1'b0 || S_TREADY !== '0 || GRANT !== '0 || BUSY !== 1'b0) begin
      failures++; $display("FAIL async_reset got mv=%b rdy=%b grant=%b busy=%b want 0", M_TVALID, S_TREADY, GRANT, BUSY);
    end
    reset_dut();
    for (int s = 0; s < 2; s++)
      for (int b = 0; b < 2; b++) srcq[s].push_back({(b == 1), 32'(32'h600 + s * 16 + b)});
    build_expected(NS - 1);
    checks++;
    if (exp_src[0] != 0) begin
      failures++; $display("FAIL model_first got src %0d want 0", exp_src[0]);
    end
    run(200, 1'b1);
  endtask

  task automatic test_random();
    int np, len;
    for (int it = 0; it < 4; it++) begin
      reset_dut();
      ready_mode = 2;
      for (int s = 0; s < NS; s++) begin
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(1, 7);
          for (int b = 0; b < len; b++) srcq[s].push_back({(b == len - 1), 32'($urandom)});
        end
      end
      build_expected(NS - 1);
      run(600, 1'b1);
    end
  endtask

  initial begin
    S_TVALID = '0; S_TDATA = '0; S_TLAST = '0; M_TREADY = 1'b1; ARESETN = 1'b0;
    stall_cnt = 0; stall_src = -1; inj_cycle = -1;
    test_reset();
    test_single();
    test_contention();
    test_burst_cap();
    test_toggle_ready();
    test_stall();
    test_reset_mid_packet();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
